// File: rtl/por_reset_sequencer.sv
// -----------------------------------------------------------------------------
// por_reset_sequencer
//
// Turns the asynchronous, active-low power-on reset from the board supervisor
// into debounced, clock-synchronous, staged reset releases. Stage 0 (clocking
// and configuration logic) is released first. Each later stage follows
// STAGE_DELAY cycles after the one before it. A one-cycle software request
// re-runs the staged release after a short hold, without the power-on debounce.
//
// Ports:
//   i_clk         block clock
//   i_rst         synchronous, active-high block reset (overrides everything)
//   i_por_n       asynchronous active-low reset from the supervisor (0 = reset)
//   i_sw_rst_req  synchronous software reset request, sampled every cycle
//   o_reset_n     staged active-low resets, bit 0 released first
//   o_ready       high while every stage is released (state RUN)
//   o_state       current state: 0 ASSERT, 1 DEBOUNCE, 2 RELEASE, 3 RUN,
//                 4 SW_HOLD
// -----------------------------------------------------------------------------
module por_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STAGE_DELAY     = 8,
  parameter int NUM_STAGES      = 3,
  parameter int SW_HOLD_CYCLES  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_por_n,
  input  logic                  i_sw_rst_req,
  output logic [NUM_STAGES-1:0] o_reset_n,
  output logic                  o_ready,
  output logic [2:0]            o_state
);

  // Parameter sanity, caught at elaboration.
  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("por_reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_err_debounce
    $error("por_reset_sequencer: DEBOUNCE_CYCLES must be >= 1");
  end
  if (STAGE_DELAY < 1) begin : g_err_delay
    $error("por_reset_sequencer: STAGE_DELAY must be >= 1");
  end
  if (NUM_STAGES < 1) begin : g_err_stages
    $error("por_reset_sequencer: NUM_STAGES must be >= 1");
  end
  if (SW_HOLD_CYCLES < 1) begin : g_err_hold
    $error("por_reset_sequencer: SW_HOLD_CYCLES must be >= 1");
  end

  localparam int MAX_A   = (DEBOUNCE_CYCLES > STAGE_DELAY) ? DEBOUNCE_CYCLES : STAGE_DELAY;
  localparam int MAX_CYC = (MAX_A > SW_HOLD_CYCLES) ? MAX_A : SW_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  // The counter is compared before it increments, so the "last" values below
  // are the counts that complete a wait on the current edge.
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  // The hold counter starts at 1 on entry and releases one edge after it
  // reaches SW_HOLD_CYCLES, keeping all resets low for SW_HOLD_CYCLES cycles.
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SW_HOLD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_ASSERT   = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_RUN      = 3'd3,
    ST_SW_HOLD  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer: the only logic that looks at i_por_n.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_por_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge; blocking here would collapse the chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_por_n};
    end
  end

  assign w_por_s = r_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [NUM_STAGES-1:0] r_reset_n, w_reset_n_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  w_release_first;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_reset_n_nxt   = r_reset_n;
    w_ready_nxt     = r_ready;
    w_release_first = 1'b0;

    if (!w_por_s) begin
      // Loss of power-good wins over software requests and counter progress.
      // In ASSERT this simply restates the cleared values.
      w_state_nxt   = ST_ASSERT;
      w_cnt_nxt     = '0;
      w_idx_nxt     = '0;
      w_reset_n_nxt = '0;
      w_ready_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          // This edge is the first high sample of the debounce window.
          if (DEBOUNCE_CYCLES == 1) begin
            w_release_first = 1'b1;
          end else begin
            w_state_nxt = ST_DEBOUNCE;
            w_cnt_nxt   = CNT_W'(1);
          end
        end

        ST_DEBOUNCE: begin
          if (r_cnt == DEB_LAST) begin
            w_release_first = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        ST_RELEASE, ST_RUN: begin
          if (i_sw_rst_req) begin
            w_state_nxt   = ST_SW_HOLD;
            w_cnt_nxt     = CNT_W'(1);
            w_idx_nxt     = '0;
            w_reset_n_nxt = '0;
            w_ready_nxt   = 1'b0;
          end else if (r_state == ST_RELEASE) begin
            if (r_cnt == STAGE_LAST) begin
              // Stages are released strictly in index order.
              w_reset_n_nxt[r_idx] = 1'b1;
              w_cnt_nxt            = '0;
              if (r_idx == IDX_LAST) begin
                w_state_nxt = ST_RUN;
                w_ready_nxt = 1'b1;
              end else begin
                w_idx_nxt = r_idx + IDX_W'(1);
              end
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end

        ST_SW_HOLD: begin
          // Further requests are ignored here, so the hold is never extended.
          if (r_cnt == HOLD_LAST) begin
            w_release_first = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        default: begin
          w_state_nxt   = ST_ASSERT;
          w_cnt_nxt     = '0;
          w_idx_nxt     = '0;
          w_reset_n_nxt = '0;
          w_ready_nxt   = 1'b0;
        end
      endcase

      // Common release of stage 0, shared by debounce completion and the end
      // of a software hold.
      if (w_release_first) begin
        w_reset_n_nxt = NUM_STAGES'(1);
        w_cnt_nxt     = '0;
        w_idx_nxt     = IDX_W'(1);
        if (NUM_STAGES == 1) begin
          w_state_nxt = ST_RUN;
          w_ready_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_RELEASE;
          w_ready_nxt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_ASSERT;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_reset_n <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_reset_n <= w_reset_n_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // All outputs come straight from flops, so they cannot glitch.
  assign o_reset_n = r_reset_n;
  assign o_ready   = r_ready;
  assign o_state   = r_state;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_por_reset_sequencer
//
// Self-checking bench for por_reset_sequencer with default parameters. Every
// clock is compared against a timeline model that tracks when stage 0 is due
// to be released and derives the released stage count arithmetically. A
// table of power-up vectors, hand-written corner sequences and a randomized
// phase drive the design.
// -----------------------------------------------------------------------------
module tb_por_reset_sequencer;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int SD   = 8;
  localparam int NS   = 3;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_por_n = 1'b0;
  logic          i_sw_rst_req = 1'b0;
  logic [NS-1:0] o_reset_n;
  logic          o_ready;
  logic [2:0]    o_state;

  always #5 clk = ~clk;

  por_reset_sequencer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .STAGE_DELAY    (SD),
    .NUM_STAGES     (NS),
    .SW_HOLD_CYCLES (HOLD)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_por_n     (i_por_n),
    .i_sw_rst_req(i_sw_rst_req),
    .o_reset_n   (o_reset_n),
    .o_ready     (o_ready),
    .o_state     (o_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: timeline of the staged release.
  //   m_active : a release sequence (or software hold) is in progress or done
  //   m_deb    : consecutive high power-good samples seen while not active
  //   m_rel0   : edge number at which stage 0 is (or was) released
  // ---------------------------------------------------------------------------
  logic          sync_m[SYNC];
  int            m_edge = 0;
  bit            m_active = 0;
  int            m_deb = 0;
  int            m_rel0 = 0;
  logic [NS-1:0] exp_rn;
  logic          exp_rdy;
  logic [2:0]    exp_st;

  task automatic model_edge(input logic rst, input logic por, input logic sw);
    logic p;
    int   k;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) sync_m[i] = 1'b0;
      m_active = 0;
      m_deb    = 0;
      m_rel0   = 0;
    end else begin
      // Value of the synchronized power-good as seen before this edge.
      p = sync_m[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
      sync_m[0] = por;
      m_edge++;
      if (!p) begin
        m_active = 0;
        m_deb    = 0;
      end else if (!m_active) begin
        m_deb++;
        if (m_deb >= DEB) begin
          m_active = 1;
          m_deb    = 0;
          m_rel0   = m_edge;
        end
      end else if (sw && (m_edge - 1 >= m_rel0)) begin
        // Accepted only once stage 0 had already been released.
        m_rel0 = m_edge + HOLD;
      end
    end

    if (!m_active) begin
      exp_rn  = '0;
      exp_rdy = 1'b0;
      exp_st  = (m_deb > 0) ? 3'd1 : 3'd0;
    end else if (m_edge < m_rel0) begin
      exp_rn  = '0;
      exp_rdy = 1'b0;
      exp_st  = 3'd4;
    end else begin
      k = (m_edge - m_rel0) / SD + 1;
      if (k > NS) k = NS;
      exp_rn  = NS'((1 << k) - 1);
      exp_rdy = (k == NS);
      exp_st  = (k == NS) ? 3'd3 : 3'd2;
    end
  endtask

  task automatic check(input string name, input logic [NS-1:0] rn, input logic rdy,
                       input logic [2:0] st);
    n_checks++;
    if ({o_reset_n, o_ready, o_state} !== {rn, rdy, st}) begin
      $display("FAIL %s @%0t: got reset_n=%b ready=%b state=%0d, expected reset_n=%b ready=%b state=%0d",
               name, $time, o_reset_n, o_ready, o_state, rn, rdy, st);
    end else begin
      n_pass++;
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later against the model.
  task automatic step(input logic rst, input logic por, input logic sw);
    i_rst        = rst;
    i_por_n      = por;
    i_sw_rst_req = sw;
    @(posedge clk);
    #1;
    model_edge(rst, por, sw);
    check("model", exp_rn, exp_rdy, exp_st);
  endtask

  task automatic steps(input int n, input logic por);
    for (int i = 0; i < n; i++) step(1'b0, por, 1'b0);
  endtask

  typedef struct {
    logic          rst;
    logic          por;
    logic          sw;
    int            reps;
    logic [NS-1:0] rn;
    logic          rdy;
    logic [2:0]    st;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Power-up vectors: edge 1 is the first edge sampling POR_N_I high.
    tbl.push_back('{1'b1, 1'b0, 1'b0,  3, 3'b000, 1'b0, 3'd0}); // RST held
    tbl.push_back('{1'b0, 1'b0, 1'b1,  3, 3'b000, 1'b0, 3'd0}); // sw ignored in ASSERT
    tbl.push_back('{1'b0, 1'b0, 1'b0,  7, 3'b000, 1'b0, 3'd0});
    tbl.push_back('{1'b0, 1'b1, 1'b0,  2, 3'b000, 1'b0, 3'd0}); // edges 1-2, sync fill
    tbl.push_back('{1'b0, 1'b1, 1'b0,  5, 3'b000, 1'b0, 3'd1}); // edges 3-7
    tbl.push_back('{1'b0, 1'b1, 1'b1,  3, 3'b000, 1'b0, 3'd1}); // sw ignored in DEBOUNCE
    tbl.push_back('{1'b0, 1'b1, 1'b0,  7, 3'b000, 1'b0, 3'd1}); // edges 11-17
    tbl.push_back('{1'b0, 1'b1, 1'b0,  8, 3'b001, 1'b0, 3'd2}); // edges 18-25
    tbl.push_back('{1'b0, 1'b1, 1'b0,  8, 3'b011, 1'b0, 3'd2}); // edges 26-33
    tbl.push_back('{1'b0, 1'b1, 1'b0,  5, 3'b111, 1'b1, 3'd3}); // edge 34 on: RUN

    foreach (tbl[v]) begin
      for (int r = 0; r < tbl[v].reps; r++) begin
        step(tbl[v].rst, tbl[v].por, tbl[v].sw);
        check("powerup_vec", tbl[v].rn, tbl[v].rdy, tbl[v].st);
      end
    end

    // Debounce glitch: one low sample in the middle of the debounce window.
    step(1'b1, 1'b1, 1'b0);
    steps(10, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("glitch_low_sampled", 3'b000, 1'b0, 3'd1);
    step(1'b0, 1'b1, 1'b0);
    check("glitch_in_sync", 3'b000, 1'b0, 3'd1);
    step(1'b0, 1'b1, 1'b0);
    check("glitch_assert", 3'b000, 1'b0, 3'd0);
    steps(15, 1'b1);
    check("glitch_recount", 3'b000, 1'b0, 3'd1);
    steps(1, 1'b1);
    check("glitch_rel0", 3'b001, 1'b0, 3'd2);
    steps(16, 1'b1);
    check("glitch_run", 3'b111, 1'b1, 3'd3);

    // Brown-out in RUN: a single low cycle on POR_N_I.
    step(1'b0, 1'b0, 1'b0);
    check("brownout_edge1", 3'b111, 1'b1, 3'd3);
    step(1'b0, 1'b1, 1'b0);
    check("brownout_edge2", 3'b111, 1'b1, 3'd3);
    step(1'b0, 1'b1, 1'b0);
    check("brownout_assert", 3'b000, 1'b0, 3'd0);
    steps(16, 1'b1);
    check("brownout_rel0", 3'b001, 1'b0, 3'd2);
    steps(16, 1'b1);
    check("brownout_run", 3'b111, 1'b1, 3'd3);

    // Software reset from RUN.
    step(1'b0, 1'b1, 1'b1);
    check("sw_enter", 3'b000, 1'b0, 3'd4);
    steps(3, 1'b1);
    check("sw_hold", 3'b000, 1'b0, 3'd4);
    steps(1, 1'b1);
    check("sw_rel0", 3'b001, 1'b0, 3'd2);
    steps(8, 1'b1);
    check("sw_rel1", 3'b011, 1'b0, 3'd2);
    steps(8, 1'b1);
    check("sw_run", 3'b111, 1'b1, 3'd3);

    // Second request during the hold must not stretch it.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("sw2_hold", 3'b000, 1'b0, 3'd4);
    steps(2, 1'b1);
    check("sw2_rel0", 3'b001, 1'b0, 3'd2);
    steps(16, 1'b1);
    check("sw2_run", 3'b111, 1'b1, 3'd3);

    // Collision: software request on the edge power-good is first seen low.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("collision", 3'b000, 1'b0, 3'd0);
    steps(32, 1'b1);
    check("collision_recover", 3'b111, 1'b1, 3'd3);

    // Synchronous reset while RESET_N = 011.
    step(1'b0, 1'b1, 1'b1);
    steps(12, 1'b1);
    check("mid_release", 3'b011, 1'b0, 3'd2);
    step(1'b1, 1'b1, 1'b0);
    check("rst_mid", 3'b000, 1'b0, 3'd0);
    steps(2, 1'b1);
    check("rst_sync_fill", 3'b000, 1'b0, 3'd0);
    steps(15, 1'b1);
    check("rst_restart_hold", 3'b000, 1'b0, 3'd1);
    steps(1, 1'b1);
    check("rst_restart_rel0", 3'b001, 1'b0, 3'd2);

    // Randomized phase against the model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 599) == 0,
           $urandom_range(0, 99) != 0,
           $urandom_range(0, 29) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
